myip_axil_reg_slave: RTL and testbench
======================================

Name: myip_axil_reg_slave

Overview:
- AXI4-Lite slave register file sitting directly downstream of the AXI VIP master in the myip_test_axi_1 block design.
- Provides four 32-bit read/write registers at byte offsets 0x0, 0x4, 0x8 and 0xC.
- Independent write and read channel FSMs, one outstanding transaction per channel.
- Register contents are exported to fabric logic.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported
C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register

Ports:
s00_axi_aclk  in  1  single clock
s00_axi_aresetn  in  1  synchronous reset, active-low
s00_axi_awaddr  in  4  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid  in  1  write address valid
s00_axi_awready  out  1  write address ready
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte enables
s00_axi_wvalid  in  1  write data valid
s00_axi_wready  out  1  write data ready
s00_axi_bresp  out  2  write response, always 2'b00
s00_axi_bvalid  out  1  write response valid
s00_axi_bready  in  1  write response ready
s00_axi_araddr  in  4  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid  in  1  read address valid
s00_axi_arready  out  1  read address ready
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  read response, always 2'b00
s00_axi_rvalid  out  1  read data valid
s00_axi_rready  in  1  read data ready
reg_out  out  128  {reg3,reg2,reg1,reg0}, registered

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (s00_axi_aresetn=0 at a rising edge):
  - reg0..3 = 0.
  - All ready, valid, resp and rdata outputs = 0.
  - Both FSMs return to IDLE.
  - Reset mid-transaction abandons it; no register write occurs; bvalid/rvalid drop at the same edge.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - awready=1 in W_IDLE and W_HAVE_DATA. wready=1 in W_IDLE and W_HAVE_ADDR. Both are 0 in W_RESP and during reset.
  - W_IDLE, AW and W handshakes in the same cycle: register written at that edge, go to W_RESP.
  - W_IDLE, AW handshake only: latch address, go to W_HAVE_ADDR.
  - W_IDLE, W handshake only: latch data and strobe, go to W_HAVE_DATA.
  - W_HAVE_ADDR/W_HAVE_DATA: on the missing handshake, write the register and go to W_RESP.
  - W_RESP: bvalid=1 and held stable until bvalid&&bready, then go to W_IDLE (bvalid=0 next cycle).
  - Latency: bvalid is high in the cycle after the completing handshake.
- Write data rules:
  - Byte i of the selected register is updated only if wstrb[i]=1.
  - wstrb=0 still completes with an OKAY response.
  - Address bits [1:0] are ignored; no SLVERR is ever generated (all 4 decodes are valid).
- Read FSM states: R_IDLE, R_DATA.
  - arready=1 only in R_IDLE.
  - On AR handshake: rdata is loaded from the register selected by araddr[3:2], rvalid=1 next cycle, go to R_DATA.
  - rdata and rvalid are held stable until rvalid&&rready, then go to R_IDLE.
  - Latency: 1 cycle from AR handshake to rvalid.
- Simultaneous AR handshake and register write to the same address at the same edge: rdata returns the OLD value.
- reg_out reflects a write in the cycle after the write edge.

Optional Feature:
- Macro: MYIP_AXIL_WR_IRQ_EN.
- When defined:
  - Adds output port wr_irq (1 bit).
  - wr_irq goes high the cycle after any write to reg3 with wdata[0]=1 and wstrb[0]=1.
  - wr_irq stays high until a write to reg3 with wdata[0]=0 and wstrb[0]=1, or until reset.
- When undefined: no wr_irq port and no related logic; all other behaviour is identical.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back 0x0..0xC -> rdata 0x1,0x2,0x3,0x4; all bresp/rresp=0; reg_out=0x00000004_00000003_00000002_00000001.
- awvalid to 0x8 asserted 3 cycles before wvalid(0xDEADBEEF) -> awready accepts immediately; bvalid 1 cycle after the W handshake; read 0x8 -> 0xDEADBEEF.
- Hold bready=0 for 5 cycles after bvalid -> bvalid stays 1, awready/wready stay 0; a new AW is accepted only after the B handshake.
- reg1=0xFFFFFFFF, then write 0x12345678 with wstrb=4'b0011 -> read 0x4 returns 0xFFFF5678.
- reg2=0xA, then AR to 0x8 in the same cycle as a completing write of 0xB to 0x8 -> rdata=0xA; a following read returns 0xB.
- Deassert aresetn for 1 cycle while rvalid=1 and bready is held low -> rvalid, bvalid, rdata and reg_out all read 0 next cycle; both FSMs accept new transactions.

Source files
------------

// File: rtl/myip_axil_reg_slave.sv
// AXI4-Lite slave with four 32-bit registers exported on reg_out.
// Optional write interrupt on reg3 bit 0 when MYIP_AXIL_WR_IRQ_EN is defined.
module myip_axil_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
`ifdef MYIP_AXIL_WR_IRQ_EN
  output logic                              wr_irq,
`endif
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_out
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW/8;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic [3:0][DW-1:0] regs_q, regs_d;
  logic [1:0]    awsel_q, awsel_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic          aw_hs, w_hs, ar_hs, wr_en;
  logic [1:0]    wr_sel;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;

  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Readies are forced low while reset is asserted, not only after the reset edge.
  assign s00_axi_awready = s00_axi_aresetn && (w_state_q == W_IDLE || w_state_q == W_HAVE_DATA);
  assign s00_axi_wready  = s00_axi_aresetn && (w_state_q == W_IDLE || w_state_q == W_HAVE_ADDR);
  assign s00_axi_arready = s00_axi_aresetn && (r_state_q == R_IDLE);
  assign s00_axi_bvalid  = (w_state_q == W_RESP);
  assign s00_axi_rvalid  = (r_state_q == R_DATA);
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_rresp   = 2'b00;
  assign s00_axi_rdata   = rdata_q;
  assign reg_out         = regs_q;

  assign aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign w_hs  = s00_axi_wvalid  && s00_axi_wready;
  assign ar_hs = s00_axi_arvalid && s00_axi_arready;

  always_comb begin
    w_state_d = w_state_q;
    awsel_d   = awsel_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wr_en     = 1'b0;
    wr_sel    = s00_axi_awaddr[3:2];
    wr_data   = s00_axi_wdata;
    wr_strb   = s00_axi_wstrb;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_en     = 1'b1;
          w_state_d = W_RESP;
        end else if (aw_hs) begin
          awsel_d   = s00_axi_awaddr[3:2];
          w_state_d = W_HAVE_ADDR;
        end else if (w_hs) begin
          wdata_d   = s00_axi_wdata;
          wstrb_d   = s00_axi_wstrb;
          w_state_d = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        wr_sel = awsel_q;
        if (w_hs) begin
          wr_en     = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_HAVE_DATA: begin
        wr_data = wdata_q;
        wr_strb = wstrb_q;
        if (aw_hs) begin
          wr_en     = 1'b1;
          w_state_d = W_RESP;
        end
      end
      default: if (s00_axi_bready) w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en)
      for (int b = 0; b < SW; b++)
        if (wr_strb[b]) regs_d[wr_sel][8*b +: 8] = wr_data[8*b +: 8];
  end

  // rdata samples regs_q, so a same-edge write to the read address returns the old value.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: if (ar_hs) begin
        rdata_d   = regs_q[s00_axi_araddr[3:2]];
        r_state_d = R_DATA;
      end
      default: if (s00_axi_rready) r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      regs_q    <= '0;
      awsel_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      regs_q    <= regs_d;
      awsel_q   <= awsel_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef MYIP_AXIL_WR_IRQ_EN
  logic irq_q;
  assign wr_irq = irq_q;
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) irq_q <= 1'b0;
    else if (wr_en && wr_sel == 2'd3 && wr_strb[0]) irq_q <= wr_data[0];
  end
`endif
endmodule

// File: tb/tb_myip_axil_reg_slave.sv
// Directed plus randomized bench for myip_axil_reg_slave against an array-based register model.
module tb_myip_axil_reg_slave;
  logic clk = 1'b0, rstn = 1'b0;
  logic [3:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [127:0] reg_out;
`ifdef MYIP_AXIL_WR_IRQ_EN
  logic wr_irq;
`endif

  myip_axil_reg_slave dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rstn),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
`ifdef MYIP_AXIL_WR_IRQ_EN
    .wr_irq(wr_irq),
`endif
    .reg_out(reg_out));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [31:0] m [4];
  logic m_irq;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic timeout(input string tag);
    total++; bad++;
    $error("FAIL %s got=timeout exp=handshake", tag);
  endtask

  function automatic logic [127:0] exp_out();
    return {m[3], m[2], m[1], m[0]};
  endfunction

  task automatic model_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) m[a[3:2]][8*b +: 8] = d[8*b +: 8];
    if (a[3:2] == 2'd3 && s[0]) m_irq = d[0];
  endtask

  task automatic clr_model();
    for (int i = 0; i < 4; i++) m[i] = '0;
    m_irq = 1'b0;
  endtask

  // Drives AW and W independently starting at the given cycle offsets; returns handshake cycles.
  task automatic axi_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int awd, input int wd, input int bhold, output int aw_at, output int w_at);
    bit awdone = 0, wdone = 0, ahs, whs;
    int cyc = 0;
    aw_at = -1; w_at = -1;
    while (!(awdone && wdone)) begin
      if (cyc > 40) begin timeout("wr_hs"); break; end
      awaddr = a; wdata = d; wstrb = s;
      awvalid = !awdone && cyc >= awd;
      wvalid  = !wdone && cyc >= wd;
      #1;
      ahs = awvalid && awready;
      whs = wvalid && wready;
      @(posedge clk);
      if (ahs) begin awdone = 1; aw_at = cyc; end
      if (whs) begin wdone = 1; w_at = cyc; end
      @(negedge clk);
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    chk("b_latency", bvalid, 1'b1);
    chk("bresp", bresp, 2'b00);
    model_wr(a, d, s);
    for (int i = 0; i < bhold; i++) begin
      chk("b_hold_bvalid", bvalid, 1'b1);
      chk("b_hold_ready", {awready, wready}, 2'b00);
      @(posedge clk); @(negedge clk);
    end
    bready = 1;
    @(posedge clk); @(negedge clk);
    bready = 0;
    chk("b_drop", bvalid, 1'b0);
    chk("reg_out", reg_out, exp_out());
`ifdef MYIP_AXIL_WR_IRQ_EN
    chk("wr_irq", wr_irq, m_irq);
`endif
  endtask

  task automatic axi_rd(input logic [3:0] a, output logic [31:0] d);
    int cyc = 0;
    bit hs = 0;
    araddr = a; arvalid = 1;
    while (!hs) begin
      if (cyc > 40) begin timeout("ar_hs"); break; end
      #1; hs = arready;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    arvalid = 0;
    chk("r_latency", rvalid, 1'b1);
    chk("rresp", rresp, 2'b00);
    d = rdata;
    rready = 1;
    @(posedge clk); @(negedge clk);
    rready = 0;
    chk("r_drop", rvalid, 1'b0);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a);
    logic [31:0] d;
    axi_rd(a, d);
    chk(tag, d, m[a[3:2]]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int aa, wa;
    logic [31:0] d;
    clr_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {awready, wready, arready}, 3'b000);
    chk("rst_valid", {bvalid, rvalid}, 2'b00);
    chk("rst_resp", {bresp, rresp}, 4'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_reg_out", reg_out, 128'h0);
    rstn = 1;
    #1;
    chk("idle_ready", {awready, wready, arready}, 3'b111);
    @(negedge clk);

    for (int i = 0; i < 4; i++) axi_wr(4'(i*4), 32'(i+1), 4'hF, 0, 0, 0, aa, wa);
    for (int i = 0; i < 4; i++) rd_chk("rb_basic", 4'(i*4));
    chk("reg_out_basic", reg_out, 128'h00000004_00000003_00000002_00000001);

    axi_wr(4'h8, 32'hDEADBEEF, 4'hF, 0, 3, 0, aa, wa);
    chk("aw_early_at", aa, 0);
    chk("w_late_at", wa, 3);
    rd_chk("rb_deadbeef", 4'h8);

    axi_wr(4'h0, 32'h5A5A5A5A, 4'hF, 0, 0, 5, aa, wa);

    axi_wr(4'h4, 32'hFFFFFFFF, 4'hF, 0, 0, 0, aa, wa);
    axi_wr(4'h5, 32'h12345678, 4'b0011, 1, 0, 0, aa, wa);
    rd_chk("rb_strobe", 4'h4);
    chk("strobe_val", m[1], 32'hFFFF5678);
    axi_wr(4'h4, 32'h0, 4'h0, 0, 0, 0, aa, wa);
    rd_chk("rb_nostrb", 4'h4);

    // AR and a completing write to the same register on one edge
    axi_wr(4'h8, 32'hA, 4'hF, 0, 0, 0, aa, wa);
    awaddr = 4'h8; wdata = 32'hB; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 4'h8; arvalid = 1;
    @(posedge clk); @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("coll_rvalid", {rvalid, bvalid}, 2'b11);
    chk("coll_old", rdata, 32'hA);
    model_wr(4'h8, 32'hB, 4'hF);
    rready = 1; bready = 1;
    @(posedge clk); @(negedge clk);
    rready = 0; bready = 0;
    rd_chk("coll_new", 4'h8);

    // Reset with both responses pending
    awaddr = 4'hC; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 4'h0; arvalid = 1;
    @(posedge clk); @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("pre_rst_valid", {rvalid, bvalid}, 2'b11);
    rstn = 0;
    @(posedge clk); @(negedge clk);
    rstn = 1;
    clr_model();
    chk("mid_rst_valid", {rvalid, bvalid}, 2'b00);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_reg_out", reg_out, 128'h0);
    axi_wr(4'hC, 32'h1, 4'hF, 0, 0, 0, aa, wa);
    rd_chk("post_rst_rd", 4'hC);
    axi_wr(4'hC, 32'h0, 4'h1, 2, 0, 0, aa, wa);

    for (int it = 0; it < 60; it++) begin
      logic [3:0] a, s;
      a = 4'($urandom_range(0, 15));
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        axi_wr(a, $urandom, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), aa, wa);
      else
        rd_chk("rand_rd", a);
    end
    for (int i = 0; i < 4; i++) rd_chk("final_rd", 4'(i*4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
